// File: rtl/sha256_pad.sv
// SHA-256 message padder: passes message words through, then appends 0x80, zero fill
// and the 64-bit bit length. Optional sticky error output enabled by SHA256_PAD_CHECK_EN.
`timescale 1ns/1ps
module sha256_pad #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic        out_final
`ifdef SHA256_PAD_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam logic [2:0] ST_DATA   = 3'd0;
  localparam logic [2:0] ST_PAD80  = 3'd1;
  localparam logic [2:0] ST_ZERO   = 3'd2;
  localparam logic [2:0] ST_LEN_HI = 3'd3;
  localparam logic [2:0] ST_LEN_LO = 3'd4;
  localparam int LEN_W = CNT_W + 3;

  logic [2:0]       state_q, state_d;
  logic [3:0]       widx_q, widx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       nb_eff;
  logic [2:0]       add_bytes;
  logic [31:0]      last_word;
  logic [LEN_W-1:0] len_bits;
  logic [63:0]      bit_len;
  logic             in_xfer;
  logic             out_xfer;

  // Oversized byte counts behave as a full word.
  assign nb_eff    = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign add_bytes = in_last ? nb_eff : 3'd4;

`ifdef SHA256_PAD_CHECK_EN
  logic err_q, err_d;
  logic cnt_carry;
  assign {cnt_carry, cnt_inc} = {1'b0, cnt_q} + (CNT_W+1)'(add_bytes);
  assign err = err_q & rst_n;
`else
  assign cnt_inc = cnt_q + CNT_W'(add_bytes);
`endif

  assign len_bits = {cnt_q, 3'b000};
  generate
    if (LEN_W >= 64) begin : g_len_wide
      assign bit_len = len_bits[63:0];
    end else begin : g_len_narrow
      assign bit_len = {{(64-LEN_W){1'b0}}, len_bits};
    end
  endgenerate

  // Last word: bytes below nb_eff pass, byte nb_eff becomes 0x80, the rest clear.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      always_comb begin
        if (3'(gi) < nb_eff) begin
          last_word[31-8*gi -: 8] = in_word[31-8*gi -: 8];
        end else if (3'(gi) == nb_eff) begin
          last_word[31-8*gi -: 8] = 8'h80;
        end else begin
          last_word[31-8*gi -: 8] = 8'h00;
        end
      end
    end
  endgenerate

  always_comb begin
    out_word  = 32'h0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_final = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_DATA: begin
          out_valid = in_valid;
          in_ready  = out_ready;
          out_word  = in_last ? last_word : in_word;
        end
        ST_PAD80: begin
          out_valid = 1'b1;
          out_word  = 32'h8000_0000;
        end
        ST_ZERO: begin
          out_valid = 1'b1;
          out_word  = 32'h0;
        end
        ST_LEN_HI: begin
          out_valid = 1'b1;
          out_word  = bit_len[63:32];
        end
        ST_LEN_LO: begin
          out_valid = 1'b1;
          out_word  = bit_len[31:0];
          out_final = 1'b1;
        end
        default: begin
          out_valid = 1'b0;
        end
      endcase
    end
  end

  assign out_idx  = rst_n ? widx_q : 4'd0;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // ZERO simply runs until word 13 goes out; wrapping through 15->0 covers the two-block case.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    if (out_xfer) begin
      widx_d = widx_q + 4'd1;
    end
    case (state_q)
      ST_DATA: begin
        if (in_xfer) begin
          cnt_d = cnt_inc;
          if (in_last) begin
            if (nb_eff == 3'd4) begin
              state_d = ST_PAD80;
            end else if (widx_q == 4'd13) begin
              state_d = ST_LEN_HI;
            end else begin
              state_d = ST_ZERO;
            end
          end
        end
      end
      ST_PAD80: begin
        if (out_xfer) begin
          state_d = (widx_q == 4'd13) ? ST_LEN_HI : ST_ZERO;
        end
      end
      ST_ZERO: begin
        if (out_xfer && (widx_q == 4'd13)) begin
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (out_xfer) begin
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (out_xfer) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          widx_d  = 4'd0;
        end
      end
      default: begin
        state_d = ST_DATA;
        cnt_d   = '0;
        widx_d  = 4'd0;
      end
    endcase
  end

`ifdef SHA256_PAD_CHECK_EN
  always_comb begin
    err_d = err_q;
    if (in_xfer && ((in_last && (in_nbytes > 3'd4)) || cnt_carry)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_DATA;
      widx_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sha256_pad.sv
// Scoreboard bench for sha256_pad: directed messages with hand-computed padded blocks.
`timescale 1ns/1ps
module tb_sha256_pad;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        fin;
    logic        pad;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_final;
`ifdef SHA256_PAD_CHECK_EN
  logic        err;
`endif

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stall_mode = 0;
  bit   prev_stall = 0;
  logic [31:0] prev_w;
  logic [3:0]  prev_idx;
  logic        prev_fin;

  sha256_pad #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_final (out_final)
`ifdef SHA256_PAD_CHECK_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_e(input logic [31:0] w, input int idx, input logic fin, input logic pad);
    exp_t x;
    x.w = w;
    x.idx = 4'(idx);
    x.fin = fin;
    x.pad = pad;
    exp_q.push_back(x);
  endtask

  // Zero words from first_zero..13, then LEN_HI (always 0 here) and LEN_LO.
  task automatic push_tail(input int first_zero, input logic [31:0] len_lo);
    for (int i = first_zero; i < 14; i++) push_e(32'h0, i, 1'b0, 1'b1);
    push_e(32'h0, 14, 1'b0, 1'b1);
    push_e(len_lo, 15, 1'b1, 1'b1);
  endtask

  task automatic send(input logic [31:0] w, input logic last, input logic [2:0] nb);
    bit done;
    done = 0;
    in_word = w;
    in_last = last;
    in_nbytes = nb;
    in_valid = 1'b1;
    for (int b = 0; b < 300 && !done; b++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: word %h not accepted", w);
    end
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d words missing, required 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      $display("msg %s: all expected words observed", name);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: compares each out transfer against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_word", out_word, prev_w);
          check("hold_idx", out_idx, prev_idx);
          check("hold_final", out_final, prev_fin);
        end
        if (!out_valid) begin
          check("idle_in_ready", in_ready, out_ready);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", out_word, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check("word", out_word, e.w);
            check("idx", out_idx, e.idx);
            check("final", out_final, e.fin);
            check("in_ready", in_ready, e.pad ? 1'b0 : 1'b1);
            $display("xfer idx=%0d word=%h final=%0d", out_idx, out_word, out_final);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_w = out_word;
        prev_idx = out_idx;
        prev_fin = out_final;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_word = 32'hDEAD_BEEF;
    in_last = 1'b1;
    in_nbytes = 3'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_final", out_final, 1'b0);
    check("rst_out_idx", out_idx, 4'd0);
    check("rst_out_word", out_word, 32'h0);
`ifdef SHA256_PAD_CHECK_EN
    check("rst_err", err, 1'b0);
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;

    // "abc"
    push_e(32'h6162_6380, 0, 1'b0, 1'b0);
    push_tail(1, 32'h18);
    send(32'h6162_6300, 1'b1, 3'd0 + 3'd3);
    drain("abc");

    // Empty message; junk bytes must be masked away
    push_e(32'h8000_0000, 0, 1'b0, 1'b0);
    push_tail(1, 32'h0);
    send(32'h1234_5678, 1'b1, 3'd0);
    drain("empty");

    // 56 bytes: padding spills into a second block
    for (int i = 0; i < 14; i++) push_e(32'h1000_0000 + i, i, 1'b0, 1'b0);
    push_e(32'h8000_0000, 14, 1'b0, 1'b1);
    push_e(32'h0, 15, 1'b0, 1'b1);
    push_tail(0, 32'h1C0);
    for (int i = 0; i < 14; i++) send(32'h1000_0000 + i, (i == 13), 3'd4);
    drain("len56");

    // 55 bytes: 0x80 lands at word 13, length follows directly
    for (int i = 0; i < 13; i++) push_e(32'h2000_0000 + i, i, 1'b0, 1'b0);
    push_e(32'h4142_4380, 13, 1'b0, 1'b0);
    push_e(32'h0, 14, 1'b0, 1'b1);
    push_e(32'h1B8, 15, 1'b1, 1'b1);
    for (int i = 0; i < 13; i++) send(32'h2000_0000 + i, 1'b0, 3'd4);
    send(32'h4142_43FF, 1'b1, 3'd3);
    drain("len55");

    // 64 bytes: 0x80 word opens the second block
    for (int i = 0; i < 16; i++) push_e(32'h3000_0000 + i, i, 1'b0, 1'b0);
    push_e(32'h8000_0000, 0, 1'b0, 1'b1);
    push_tail(1, 32'h200);
    for (int i = 0; i < 16; i++) send(32'h3000_0000 + i, (i == 15), 3'd4);
    drain("len64");

    // in_nbytes=5 behaves as 4
    push_e(32'h1122_3344, 0, 1'b0, 1'b0);
    push_e(32'h8000_0000, 1, 1'b0, 1'b1);
    push_tail(2, 32'h20);
    send(32'h1122_3344, 1'b1, 3'd5);
    drain("nb5");
`ifdef SHA256_PAD_CHECK_EN
    @(negedge clk);
    check("err_set", err, 1'b1);
    push_e(32'h6162_6380, 0, 1'b0, 1'b0);
    push_tail(1, 32'h18);
    send(32'h6162_6300, 1'b1, 3'd3);
    drain("abc_err");
    @(negedge clk);
    check("err_sticky", err, 1'b1);
    pulse_reset();
    @(negedge clk);
    check("err_cleared", err, 1'b0);
`endif

    // Stalled 3-word message followed back-to-back by "abc"
    stall_mode = 1;
    push_e(32'hA0A0_A0A0, 0, 1'b0, 1'b0);
    push_e(32'hB1B1_B1B1, 1, 1'b0, 1'b0);
    push_e(32'hAABB_8000, 2, 1'b0, 1'b0);
    push_tail(3, 32'h50);
    push_e(32'h6162_6380, 0, 1'b0, 1'b0);
    push_tail(1, 32'h18);
    send(32'hA0A0_A0A0, 1'b0, 3'd4);
    send(32'hB1B1_B1B1, 1'b0, 3'd4);
    send(32'hAABB_CCDD, 1'b1, 3'd2);
    send(32'h6162_6300, 1'b1, 3'd3);
    drain("stall_b2b");
    stall_mode = 0;
    @(posedge clk);
    #1;

    // Reset mid-message: the next message must restart at word 0
    push_e(32'h0102_0304, 0, 1'b0, 1'b0);
    push_e(32'h0506_0708, 1, 1'b0, 1'b0);
    send(32'h0102_0304, 1'b0, 3'd4);
    send(32'h0506_0708, 1'b0, 3'd4);
    drain("partial");
    pulse_reset();
    push_e(32'h6162_6380, 0, 1'b0, 1'b0);
    push_tail(1, 32'h18);
    send(32'h6162_6300, 1'b1, 3'd3);
    drain("abc_after_rst");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
